// File: rtl/test_006_if.sv
// ---------------------------------------------------------------------------
// test_006_if
// Method-call handshake between a sequencer and the test_006 kernel.
//   test_req    : start request, level-sensitive (sequencer -> kernel)
//   test_busy   : high while a run is in progress (kernel -> sequencer)
//   test_return : pass(1)/fail(0) result of the last completed run
// ---------------------------------------------------------------------------
interface test_006_if;
    logic test_req;
    logic test_busy;
    logic test_return;

    modport master (
        output test_req,
        input  test_busy,
        input  test_return
    );

    modport slave (
        input  test_req,
        output test_busy,
        output test_return
    );
endinterface

// File: rtl/test_006.sv
// ---------------------------------------------------------------------------
// test_006
// Self-checking memory/arithmetic kernel. A request fills an internal array
// with a[i] = 3*i + 1, reads it back, checks every element and the total sum,
// and reports pass/fail on test_return.
// Ports:
//   clk   : system clock, rising edge
//   reset : asynchronous, active-low reset
//   bus   : test_006_if.slave (test_req in, test_busy / test_return out)
// Parameters:
//   N : array length (2..1024)
//   W : data/accumulator width (must hold 3*N*(N-1)/2 + N)
// ---------------------------------------------------------------------------
module test_006 #(
    parameter int N = 32,
    parameter int W = 32
) (
    input  logic       clk,
    input  logic       reset,
    test_006_if.slave  bus
);

    localparam int AW = $clog2(N);
    localparam int IW = $clog2(N) + 1;

    localparam logic [IW-1:0] LAST_IDX = IW'(N - 1);
    localparam logic [IW-1:0] END_IDX  = IW'(N);
    localparam logic [W-1:0]  EXP_SUM  = W'((3 * N * (N - 1)) / 2 + N);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_WRITE = 3'd1,
        S_READ  = 3'd2,
        S_CHECK = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t          state_q;
    logic [IW-1:0]   idx_q;
    logic [W-1:0]    sum_q;
    logic            err_q;
    logic            busy_q;
    logic            ret_q;

    logic [W-1:0]    mem_q [N];
    logic [W-1:0]    rd_q;

    logic            wr_en_s;
    logic            rd_en_s;
    logic [AW-1:0]   addr_s;
    logic [W-1:0]    wdata_s;

    // Reference pattern stored at (and expected back from) position i.
    function automatic logic [W-1:0] entry_value(input logic [IW-1:0] i);
        return W'(32'd3) * W'(i) + W'(32'd1);
    endfunction

    assign addr_s  = idx_q[AW-1:0];
    assign wdata_s = entry_value(idx_q);

    // Memory port enables; the read is suppressed on the final READ cycle,
    // where idx_q == N only drains the last returned word.
    always_comb begin
        wr_en_s = 1'b0;
        rd_en_s = 1'b0;
        if (state_q == S_WRITE) begin
            wr_en_s = 1'b1;
        end else begin
            wr_en_s = 1'b0;
        end
        if ((state_q == S_READ) && (idx_q < END_IDX)) begin
            rd_en_s = 1'b1;
        end else begin
            rd_en_s = 1'b0;
        end
    end

    // Array storage with a registered (1-cycle latency) read port.
    always_ff @(posedge clk) begin
        if (wr_en_s) begin
            mem_q[addr_s] <= wdata_s;
        end
        if (rd_en_s) begin
            rd_q <= mem_q[addr_s];
        end
    end

    // Control FSM with registered busy/return outputs and the checker datapath.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            idx_q   <= {IW{1'b0}};
            sum_q   <= {W{1'b0}};
            err_q   <= 1'b0;
            busy_q  <= 1'b0;
            ret_q   <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (bus.test_req) begin
                        state_q <= S_WRITE;
                        idx_q   <= {IW{1'b0}};
                        sum_q   <= {W{1'b0}};
                        err_q   <= 1'b0;
                        busy_q  <= 1'b1;
                    end else begin
                        busy_q  <= 1'b0;
                    end
                end
                S_WRITE: begin
                    if (idx_q == LAST_IDX) begin
                        idx_q   <= {IW{1'b0}};
                        state_q <= S_READ;
                    end else begin
                        idx_q   <= idx_q + IW'(1);
                    end
                end
                S_READ: begin
                    // rd_q holds the word for position idx_q-1 (issued last cycle).
                    if (idx_q != {IW{1'b0}}) begin
                        sum_q <= sum_q + rd_q;
                        if (rd_q != entry_value(idx_q - IW'(1))) begin
                            err_q <= 1'b1;
                        end else begin
                            err_q <= err_q;
                        end
                    end else begin
                        sum_q <= sum_q;
                    end
                    if (idx_q == END_IDX) begin
                        state_q <= S_CHECK;
                    end else begin
                        idx_q   <= idx_q + IW'(1);
                    end
                end
                S_CHECK: begin
                    ret_q   <= (!err_q) && (sum_q == EXP_SUM);
                    busy_q  <= 1'b0;
                    state_q <= S_DONE;
                end
                S_DONE: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.test_busy   = busy_q;
    assign bus.test_return = ret_q;

endmodule

// File: tb/tb_test_006.sv
module tb_test_006;

    logic clk;
    logic reset;

    int n_cmp;
    int n_fail;

    test_006_if bus ();
    test_006_if bus4 ();

    test_006 #(.N(32), .W(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    test_006 #(.N(4), .W(32)) dut4 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Behavioural model: build the array, apply an optional corruption,
    // then verify every element and the closed-form sum.
    function automatic logic model_pass(input int n, input int cidx, input logic [31:0] cval);
        logic [31:0] a[$];
        logic [31:0] s;
        logic        ok;
        s  = 32'd0;
        ok = 1'b1;
        for (int i = 0; i < n; i++) a.push_back(32'(3 * i + 1));
        if (cidx >= 0) a[cidx] = cval;
        for (int i = 0; i < n; i++) begin
            s = s + a[i];
            if (a[i] != 32'(3 * i + 1)) ok = 1'b0;
        end
        return ok && (s == 32'((3 * n * (n - 1)) / 2 + n));
    endfunction

    task automatic set_req(input int sel, input logic v);
        if (sel == 0) bus.test_req = v;
        else          bus4.test_req = v;
    endtask

    // One request: hold test_req for 'hold' cycles, optionally corrupt a[cidx]
    // once WRITE has finished, then check busy duration and the result.
    task automatic do_run(input int sel, input int n, input int hold, input int cidx,
                          input logic [31:0] xv);
        int          cnt;
        logic        b;
        logic        r;
        logic        done;
        logic        pass_exp;
        logic [31:0] cval;
        cval     = 32'(3 * cidx + 1) ^ xv;
        pass_exp = model_pass(n, cidx, cval);
        @(negedge clk);
        set_req(sel, 1'b1);
        cnt  = 0;
        done = 1'b0;
        while (!done && cnt < 400) begin
            @(posedge clk);
            #1;
            cnt++;
            if (cnt == hold) set_req(sel, 1'b0);
            b = (sel == 0) ? bus.test_busy : bus4.test_busy;
            if (cnt == 1) chk("busy_rise", 32'(b), 32'd1);
            if (sel == 0 && cidx >= 0 && cnt == n + 1) dut.mem_q[cidx] = cval;
            if (cnt > 1 && !b) done = 1'b1;
        end
        set_req(sel, 1'b0);
        r = (sel == 0) ? bus.test_return : bus4.test_return;
        chk("busy_len", 32'(cnt), 32'(2 * n + 3));
        chk("return", 32'(r), 32'(pass_exp));
    endtask

    initial begin
        int          hold;
        int          cidx;
        int          gap;
        int          cyc;
        logic        prev_b;
        logic        seen_fall;
        logic [31:0] xv;

        n_cmp         = 0;
        n_fail        = 0;
        bus.test_req  = 1'b0;
        bus4.test_req = 1'b0;
        reset         = 1'b0;

        // Reset hold
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", 32'(bus.test_busy), 32'd0);
        chk("rst_return", 32'(bus.test_return), 32'd0);
        chk("rst_busy4", 32'(bus4.test_busy), 32'd0);
        @(negedge clk);
        reset = 1'b1;

        // Idle with no request: outputs stay low
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            chk("idle_busy", 32'(bus.test_busy), 32'd0);
            chk("idle_return", 32'(bus.test_return), 32'd0);
        end

        // Single-cycle pulse, clean run
        do_run(0, 32, 1, -1, 32'd0);
        repeat (3) @(posedge clk);

        // Corrupt a[5] during READ, then a clean run
        do_run(0, 32, 1, 5, 32'h0000_0100);
        repeat (3) @(posedge clk);
        do_run(0, 32, 2, -1, 32'd0);

        // Randomized runs
        for (int k = 0; k < 6; k++) begin
            repeat ($urandom_range(2, 15)) @(posedge clk);
            hold = int'($urandom_range(1, 10));
            if ($urandom_range(0, 2) == 0) cidx = int'($urandom_range(0, 31));
            else                           cidx = -1;
            xv = $urandom | 32'd1;
            do_run(0, 32, hold, cidx, xv);
        end
        repeat (3) @(posedge clk);
        do_run(0, 32, 1, -1, 32'd0);

        // Continuous request: back-to-back runs with a low gap between them
        @(negedge clk);
        bus.test_req = 1'b1;
        prev_b    = 1'b0;
        seen_fall = 1'b0;
        gap       = 0;
        for (int i = 0; i < 250; i++) begin
            @(posedge clk);
            #1;
            if (bus.test_busy) begin
                if (!prev_b && seen_fall) chk("gap_ge2", 32'(gap >= 2), 32'd1);
                gap = 0;
            end else begin
                if (prev_b) begin
                    seen_fall = 1'b1;
                    chk("cont_return", 32'(bus.test_return), 32'd1);
                end
                gap++;
            end
            prev_b = bus.test_busy;
        end
        bus.test_req = 1'b0;
        cyc = 0;
        while (bus.test_busy && cyc < 200) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        chk("cont_drain", 32'(bus.test_busy), 32'd0);
        repeat (2) @(posedge clk);

        // Reset in the middle of WRITE aborts at once
        #1;
        chk("pre_abort_return", 32'(bus.test_return), 32'd1);
        @(negedge clk);
        bus.test_req = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        bus.test_req = 1'b0;
        chk("mid_busy", 32'(bus.test_busy), 32'd1);
        #2;
        reset = 1'b0;
        #1;
        chk("abort_busy", 32'(bus.test_busy), 32'd0);
        chk("abort_return", 32'(bus.test_return), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(posedge clk);
        do_run(0, 32, 1, -1, 32'd0);

        // N=4 build
        repeat (3) @(posedge clk);
        do_run(1, 4, 1, -1, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
